// File: rtl/master_alu_ram_pkg.sv
// Shared definitions for the master CPU datapath core: ALU opcodes, condition
// codes, NZCV flag bit positions and the condition evaluator.
package master_alu_ram_pkg;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] C_EQ = 4'h0;
  localparam logic [3:0] C_NE = 4'h1;
  localparam logic [3:0] C_CS = 4'h2;
  localparam logic [3:0] C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4;
  localparam logic [3:0] C_PL = 4'h5;
  localparam logic [3:0] C_VS = 4'h6;
  localparam logic [3:0] C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8;
  localparam logic [3:0] C_LS = 4'h9;
  localparam logic [3:0] C_GE = 4'hA;
  localparam logic [3:0] C_LT = 4'hB;
  localparam logic [3:0] C_GT = 4'hC;
  localparam logic [3:0] C_LE = 4'hD;
  localparam logic [3:0] C_AL = 4'hE;
  localparam logic [3:0] C_NV = 4'hF;

  localparam int F_N = 3;
  localparam int F_Z = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flag);
    logic n, z, c, v, pass;
    n = flag[F_N];
    z = flag[F_Z];
    c = flag[F_C];
    v = flag[F_V];
    case (cond)
      C_EQ:    pass = z;
      C_NE:    pass = ~z;
      C_CS:    pass = c;
      C_CC:    pass = ~c;
      C_MI:    pass = n;
      C_PL:    pass = ~n;
      C_VS:    pass = v;
      C_VC:    pass = ~v;
      C_HI:    pass = c & ~z;
      C_LS:    pass = ~c | z;
      C_GE:    pass = (n == v);
      C_LT:    pass = (n != v);
      C_GT:    pass = ~z & (n == v);
      C_LE:    pass = z | (n != v);
      C_AL:    pass = 1'b1;
      C_NV:    pass = 1'b0;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/master_ram.sv
// Single-port word RAM for the master core: synchronous write, registered read
// with one-cycle latency; out-of-range addresses drop writes and read as zero.
module master_ram #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        RW,
  input  logic [15:0] Address,
  input  logic [31:0] In,
  output logic [31:0] Out
);

  localparam int AW = $clog2(MEM_DEPTH);

  logic [31:0]   Mem [MEM_DEPTH];
  logic [AW-1:0] idx_s;
  logic          in_range_s;
  logic          wr_s;
  logic [31:0]   out_d;
  logic [31:0]   out_q;

  always_comb begin
    idx_s      = Address[AW-1:0];
    in_range_s = ({16'h0000, Address} < 32'(MEM_DEPTH));
    wr_s       = Enable & ~RW & in_range_s & ~Reset;
    if (Enable && RW) begin
      if (in_range_s) begin
        out_d = Mem[idx_s];
      end else begin
        out_d = 32'h0000_0000;
      end
    end else begin
      out_d = out_q;
    end
  end

  // Contents survive reset; a write on an edge with Reset high is suppressed via wr_s.
  always_ff @(posedge Clk) begin
    if (wr_s) begin
      Mem[idx_s] <= In;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_q <= 32'h0000_0000;
    end else begin
      out_q <= out_d;
    end
  end

  assign Out = out_q;

endmodule

// File: rtl/master_alu_ram.sv
// Datapath core of the master CPU: condition-gated 32-bit ALU with an NZCV
// flag register, plus the word RAM sharing the same clock.
module master_alu_ram
  import master_alu_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Reg1,
  input  logic [31:0] Reg2,
  input  logic [15:0] IV,
  input  logic        Imm_Sel,
  input  logic [3:0]  OpCode,
  input  logic [3:0]  Cond,
  input  logic        S,
  output logic [31:0] Result,
  output logic        Wr_En,
  output logic [3:0]  New_Flag,
  output logic [3:0]  Flag,
  input  logic        Enable,
  input  logic        RW,
  input  logic [15:0] Address,
  input  logic [31:0] In,
  output logic [31:0] Out
);

  logic [3:0]  flag_d, flag_q;
  logic [31:0] op_b_s, add_x_s, add_y_s, raw_s;
  logic [32:0] sum_s;
  logic        add_cin_s, is_arith_s, is_test_s, pass_s, commit_s;

  // Every add/sub form reduces to x + y + cin; subtraction uses the inverted operand.
  always_comb begin
    op_b_s     = Imm_Sel ? {16'h0000, IV} : Reg2;
    add_x_s    = Reg1;
    add_y_s    = op_b_s;
    add_cin_s  = 1'b0;
    is_arith_s = 1'b1;
    case (OpCode)
      OP_SUB, OP_CMP: begin add_y_s = ~op_b_s; add_cin_s = 1'b1; end
      OP_RSB:         begin add_x_s = op_b_s; add_y_s = ~Reg1; add_cin_s = 1'b1; end
      OP_ADD, OP_CMN: add_cin_s = 1'b0;
      OP_ADC:         add_cin_s = flag_q[F_C];
      OP_SBC:         begin add_y_s = ~op_b_s; add_cin_s = flag_q[F_C]; end
      OP_RSC:         begin add_x_s = op_b_s; add_y_s = ~Reg1; add_cin_s = flag_q[F_C]; end
      default:        is_arith_s = 1'b0;
    endcase
    sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {32'h0000_0000, add_cin_s};

    case (OpCode)
      OP_AND, OP_TST: raw_s = Reg1 & op_b_s;
      OP_EOR, OP_TEQ: raw_s = Reg1 ^ op_b_s;
      OP_ORR:         raw_s = Reg1 | op_b_s;
      OP_MOV:         raw_s = op_b_s;
      OP_BIC:         raw_s = Reg1 & ~op_b_s;
      OP_MVN:         raw_s = ~op_b_s;
      default:        raw_s = sum_s[31:0];
    endcase

    New_Flag[F_N] = raw_s[31];
    New_Flag[F_Z] = (raw_s == 32'h0000_0000);
    if (is_arith_s) begin
      New_Flag[F_C] = sum_s[32];
      New_Flag[F_V] = (add_x_s[31] == add_y_s[31]) && (sum_s[31] != add_x_s[31]);
    end else begin
      New_Flag[F_C] = flag_q[F_C];
      New_Flag[F_V] = flag_q[F_V];
    end

    is_test_s = (OpCode[3:2] == 2'b10);
    pass_s    = cond_pass(Cond, flag_q);
    commit_s  = pass_s & (S | is_test_s);
    Result    = pass_s ? raw_s : 32'h0000_0000;
    Wr_En     = pass_s & ~is_test_s;
    flag_d    = commit_s ? New_Flag : flag_q;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      flag_q <= 4'h0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign Flag = flag_q;

  master_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
    .Clk     (Clk),
    .Reset   (Reset),
    .Enable  (Enable),
    .RW      (RW),
    .Address (Address),
    .In      (In),
    .Out     (Out)
  );

endmodule

// File: tb/tb_master_alu_ram.sv
// Scoreboard bench for master_alu_ram: a driver pushes reference-model
// expectations into queues, a monitor pops them as the DUT presents results.
module tb_master_alu_ram;

  localparam int DEPTH = 256;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] Reg1, Reg2, In;
  logic [15:0] IV, Address;
  logic        Imm_Sel, S, Enable, RW;
  logic [3:0]  OpCode, Cond;
  logic [31:0] Result, Out;
  logic        Wr_En;
  logic [3:0]  New_Flag, Flag;

  master_alu_ram #(.MEM_DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .Reg1(Reg1), .Reg2(Reg2), .IV(IV), .Imm_Sel(Imm_Sel),
    .OpCode(OpCode), .Cond(Cond), .S(S), .Result(Result), .Wr_En(Wr_En),
    .New_Flag(New_Flag), .Flag(Flag), .Enable(Enable), .RW(RW), .Address(Address),
    .In(In), .Out(Out)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] res;
    logic        wr;
    logic [3:0]  nf;
    logic [3:0]  flag;
  } alu_exp_t;

  alu_exp_t    alu_q[$];
  logic [31:0] ram_q[$];
  logic [31:0] mem_model [int];
  int          wlist[$];
  logic [3:0]  model_flag;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU from arithmetic definitions: wide signed/unsigned sums.
  function automatic void ref_alu(input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] op, input logic [3:0] cond,
                                  input logic [3:0] fl, input logic s,
                                  output alu_exp_t e, output logic commit);
    longint sa, sb, sr, cin;
    longint unsigned ua, ub, brw;
    logic [31:0] r;
    logic c, v, arith, pass, n, z, test;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = a; ub = b;
    cin = fl[1] ? 64'sd1 : 64'sd0;
    brw = fl[1] ? 64'd0 : 64'd1;
    arith = 1'b1; c = fl[1]; v = fl[0]; sr = 0; r = 32'h0;
    case (op)
      4'h0, 4'h8: begin r = a & b; arith = 1'b0; end
      4'h1, 4'h9: begin r = a ^ b; arith = 1'b0; end
      4'h2, 4'hA: begin sr = sa - sb; c = (ua >= ub); end
      4'h3:       begin sr = sb - sa; c = (ub >= ua); end
      4'h4, 4'hB: begin sr = sa + sb; c = ((ua + ub) >> 32) != 0; end
      4'h5:       begin sr = sa + sb + cin; c = ((ua + ub + 64'(fl[1])) >> 32) != 0; end
      4'h6:       begin sr = sa - sb - (64'sd1 - cin); c = (ua >= ub + brw); end
      4'h7:       begin sr = sb - sa - (64'sd1 - cin); c = (ub >= ua + brw); end
      4'hC:       begin r = a | b; arith = 1'b0; end
      4'hD:       begin r = b; arith = 1'b0; end
      4'hE:       begin r = a & ~b; arith = 1'b0; end
      default:    begin r = ~b; arith = 1'b0; end
    endcase
    if (arith) begin
      r = sr[31:0];
      v = (sr > SMAX) || (sr < SMIN);
    end
    n = fl[3]; z = fl[2];
    case (cond)
      4'h0: pass = z;         4'h1: pass = !z;
      4'h2: pass = fl[1];     4'h3: pass = !fl[1];
      4'h4: pass = n;         4'h5: pass = !n;
      4'h6: pass = fl[0];     4'h7: pass = !fl[0];
      4'h8: pass = fl[1] && !z;   4'h9: pass = !fl[1] || z;
      4'hA: pass = (n == fl[0]);  4'hB: pass = (n != fl[0]);
      4'hC: pass = !z && (n == fl[0]);
      4'hD: pass = z || (n != fl[0]);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    test = (op >= 4'h8) && (op <= 4'hB);
    e.res  = pass ? r : 32'h0;
    e.wr   = pass && !test;
    e.nf   = {r[31], (r == 32'h0), c, v};
    e.flag = fl;
    commit = pass && (s || test);
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [15:0] iv,
                       input logic isel, input logic [3:0] op, input logic [3:0] cond,
                       input logic s, input logic en, input logic rw,
                       input logic [15:0] addr, input logic [31:0] din);
    alu_exp_t e;
    logic commit;
    @(negedge Clk);
    Reg1 = a; Reg2 = b; IV = iv; Imm_Sel = isel; OpCode = op; Cond = cond; S = s;
    Enable = en; RW = rw; Address = addr; In = din;
    ref_alu(a, isel ? {16'h0, iv} : b, op, cond, model_flag, s, e, commit);
    if (commit) model_flag = e.nf;
    alu_q.push_back(e);
    if (en && !rw && int'(addr) < DEPTH) begin
      if (!mem_model.exists(int'(addr))) wlist.push_back(int'(addr));
      mem_model[int'(addr)] = din;
    end
    if (en && rw) ram_q.push_back(int'(addr) < DEPTH ? mem_model[int'(addr)] : 32'h0);
  endtask

  task automatic ram_op(input logic en, input logic rw, input logic [15:0] addr, input logic [31:0] din);
    drive(32'h0, 32'h0, 16'h0, 1'b0, 4'hD, 4'hF, 1'b0, en, rw, addr, din);
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [15:0] iv,
                        input logic isel, input logic [3:0] op, input logic [3:0] cond, input logic s);
    drive(a, b, iv, isel, op, cond, s, 1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'(($urandom_range(0, 7)));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: reads back what the DUT presents and pops the matching expectation.
  logic        rd_seen = 1'b0, rst_seen = 1'b0;
  logic [31:0] held_out = 32'h0;
  alu_exp_t    mon_e;

  always @(posedge Clk) begin
    rd_seen  <= Enable && RW && !Reset;
    rst_seen <= Reset;
  end

  always @(negedge Clk) begin
    #2;
    if (alu_q.size() > 0) begin
      mon_e = alu_q.pop_front();
      check("result",   Result, mon_e.res);
      check("wr_en",    32'(Wr_En), 32'(mon_e.wr));
      check("new_flag", 32'(New_Flag), 32'(mon_e.nf));
      check("flag",     32'(Flag), 32'(mon_e.flag));
    end
    if (rst_seen || Reset) begin
      held_out = 32'h0;
    end else if (rd_seen) begin
      if (ram_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL ram_unexpected_read: got %h expected no read", Out);
      end else begin
        held_out = ram_q.pop_front();
      end
    end
    check("ram_out", Out, held_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    alu_exp_t e;
    logic commit;
    logic [31:0] d;
    logic [15:0] ra;
    Reset = 1'b1; Reg1 = 32'h0; Reg2 = 32'h0; IV = 16'h0; Imm_Sel = 1'b0;
    OpCode = 4'h0; Cond = 4'hF; S = 1'b0; Enable = 1'b0; RW = 1'b0;
    Address = 16'h0; In = 32'h0; model_flag = 4'h0;
    repeat (2) @(negedge Clk);
    #1;
    check("reset_flag", 32'(Flag), 32'h0);
    check("reset_out", Out, 32'h0);
    Reset = 1'b0;

    // RAM fill, overwrite and readback
    ram_op(1'b1, 1'b0, 16'h0000, 32'hAAAA_AAAA);
    ram_op(1'b1, 1'b0, 16'h0000, 32'hABBB_AAAA);
    for (int i = 1; i <= 16; i++) begin
      d = (i == 16) ? 32'hCCCC_FFFF : 32'hCCCC_00AA + 32'((i - 1) * 32'h1000);
      ram_op(1'b1, 1'b0, 16'(i), d);
    end
    for (int i = 0; i <= 16; i++) ram_op(1'b1, 1'b1, 16'(i), 32'h0);
    ram_op(1'b1, 1'b1, 16'h0000, 32'h0);
    @(posedge Clk); #1;
    check("t1_addr0", Out, 32'hABBB_AAAA);

    // Signed overflow on ADD
    alu_op(32'h7FFF_FFFF, 32'h1, 16'h0, 1'b0, 4'h4, 4'hE, 1'b1);
    #1 check("t2_result", Result, 32'h8000_0000);
    @(posedge Clk); #1 check("t2_flag", 32'(Flag), 32'h9);

    // CMP commits without S; MOV under EQ
    alu_op(32'd5, 32'd5, 16'h0, 1'b0, 4'hA, 4'hE, 1'b0);
    #1 check("t3_cmp_wr", 32'(Wr_En), 32'h0);
    @(posedge Clk); #1 check("t3_flag", 32'(Flag), 32'h6);
    alu_op(32'h0, 32'h0, 16'h1234, 1'b1, 4'hD, 4'h0, 1'b0);
    #1 check("t3_mov", Result, 32'h0000_1234);
    check("t3_mov_wr", 32'(Wr_En), 32'h1);

    // Failing conditions
    alu_op(32'h3, 32'h4, 16'h0, 1'b0, 4'h4, 4'h1, 1'b1);
    #1 check("t4_ne_res", Result, 32'h0);
    alu_op(32'h3, 32'h4, 16'h0, 1'b0, 4'h4, 4'hF, 1'b1);
    #1 check("t4_nv_wr", 32'(Wr_En), 32'h0);
    @(posedge Clk); #1 check("t4_flag", 32'(Flag), 32'h6);

    // Carry-in paths
    alu_op(32'hFFFF_FFFF, 32'h0, 16'h0, 1'b0, 4'h5, 4'hE, 1'b1);
    #1 check("t5_adc", Result, 32'h0);
    @(posedge Clk); #1 check("t5_flag", 32'(Flag), 32'h6);
    alu_op(32'h1, 32'h1, 16'h0, 1'b0, 4'h4, 4'hE, 1'b1);
    alu_op(32'd5, 32'd3, 16'h0, 1'b0, 4'h6, 4'hE, 1'b0);
    #1 check("t5_sbc", Result, 32'h1);

    // Reset mid-sequence with a write attempt, then out-of-range access
    ram_op(1'b1, 1'b1, 16'h0001, 32'h0);
    ram_op(1'b0, 1'b1, 16'h0001, 32'h0);
    @(negedge Clk);
    Reset = 1'b1; Cond = 4'hF; Enable = 1'b1; RW = 1'b0; Address = 16'h0003; In = 32'hDEAD_BEEF;
    model_flag = 4'h0;
    ref_alu(Reg1, Imm_Sel ? {16'h0, IV} : Reg2, OpCode, Cond, model_flag, S, e, commit);
    alu_q.push_back(e);
    #1;
    check("t6_rst_flag", 32'(Flag), 32'h0);
    check("t6_rst_out", Out, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    alu_q.push_back(e);
    Enable = 1'b0;
    ram_op(1'b1, 1'b1, 16'h0003, 32'h0);
    @(posedge Clk); #1 check("t6_lost_write", Out, 32'hCCCC_20AA);
    ram_op(1'b1, 1'b0, 16'h0100, 32'h1234_5678);
    ram_op(1'b1, 1'b1, 16'h0100, 32'h0);
    @(posedge Clk); #1 check("t6_oob_read", Out, 32'h0);

    // Randomized ALU and RAM traffic
    for (int k = 0; k < 400; k++) begin
      logic en, rw;
      en = ($urandom_range(0, 3) != 0);
      rw = $urandom_range(0, 1);
      if (rw) begin
        if (wlist.size() == 0 || $urandom_range(0, 7) == 0) ra = 16'(DEPTH + $urandom_range(0, 1000));
        else ra = 16'(wlist[$urandom_range(0, wlist.size() - 1)]);
      end else begin
        ra = ($urandom_range(0, 7) == 0) ? 16'(DEPTH + $urandom_range(0, 1000)) : 16'($urandom_range(0, DEPTH - 1));
      end
      drive(pick_operand(), pick_operand(), 16'($urandom), $urandom_range(0, 1),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 1),
            en, rw, ra, $urandom);
    end

    repeat (3) ram_op(1'b0, 1'b0, 16'h0, 32'h0);
    @(negedge Clk); #5;
    check("alu_q_drained", 32'(alu_q.size()), 32'h0);
    check("ram_q_drained", 32'(ram_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
